// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution window controller:
//   - state_t : controller FSM states (IDLE / RUN / DRAIN)
//   - cw_of() : coordinate counter width for a given image edge length
// -----------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Width needed to hold coordinates 0..n-1. Never returns 0 so that a
    // degenerate 1-pixel image still gets a legal 1-bit vector.
    function automatic int cw_of(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Modulo-MODULUS up-counter with synchronous clear and enable.
// Ports:
//   clock    in   clock, counts on posedge
//   reset_n  in   asynchronous active-low reset (count -> 0)
//   i_clear  in   synchronous clear to 0 (has priority over i_enable)
//   i_enable in   advance the count by one
//   o_count  out  current count, 0..MODULUS-1
//   o_wrap   out  combinational: this enabled step wraps MODULUS-1 -> 0
// -----------------------------------------------------------------------------
module wrap_counter
    import conv_pkg::*;
#(
    parameter int MODULUS = 11,
    parameter int WIDTH   = cw_of(MODULUS)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_at_last ? '0 : r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_wrap  = i_enable && !i_clear && w_at_last;

endmodule

// File: rtl/conv_window_ctrl.sv
// -----------------------------------------------------------------------------
// conv_window_ctrl
// Sequencing controller for a line-buffer based sliding-window convolution.
// Counts raster pixels of an imageWidth x imageWidth frame, advances the
// external line buffers through shift_enable, and announces each complete
// filterWidth x filterWidth window (top-left coordinate) to the downstream MAC
// with a valid/ready handshake. No pixel data passes through this block.
// Ports:
//   clock        in   single clock, posedge
//   reset_n      in   asynchronous active-low reset
//   start        in   begin a frame (only looked at in IDLE)
//   in_valid     in   upstream pixel available
//   in_ready     out  controller accepts a pixel this cycle
//   shift_enable out  line-buffer shift, high exactly on accepted pixels
//   out_valid    out  a complete window sits in the line buffers
//   out_ready    in   downstream consumes the window
//   win_row      out  top row of the presented window
//   win_col      out  left column of the presented window
//   busy         out  state is not IDLE
//   frame_done   out  one-cycle pulse when the frame has fully drained
// -----------------------------------------------------------------------------
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter  int bitwidth    = 8,
    parameter  int imageWidth  = 11,
    parameter  int filterWidth = 3,
    localparam int CW          = cw_of(imageWidth)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          shift_enable,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          busy,
    output logic          frame_done
);

    // Pixel width belongs to the external line buffers; only sanity-checked here.
    if (bitwidth < 1 || filterWidth < 1 || filterWidth > imageWidth) begin : g_bad_params
        $error("conv_window_ctrl: illegal bitwidth/filterWidth/imageWidth combination");
    end

    localparam logic [CW-1:0] FW_M1 = CW'(filterWidth - 1);

    state_t        r_state;
    state_t        w_state_next;

    logic [CW-1:0] w_row;
    logic [CW-1:0] w_col;
    logic          w_col_wrap;
    logic          w_row_wrap;

    logic          w_start_frame;
    logic          w_accept;
    logic          w_win_complete;
    logic          w_win_taken;

    logic          r_out_valid;
    logic [CW-1:0] r_win_row;
    logic [CW-1:0] r_win_col;
    logic          r_frame_done;

    assign w_start_frame  = (r_state == ST_IDLE) && start;
    assign w_accept       = in_valid && in_ready;
    assign w_win_taken    = r_out_valid && out_ready;
    // The window whose bottom-right pixel is being accepted right now.
    assign w_win_complete = w_accept && (w_row >= FW_M1) && (w_col >= FW_M1);

    // ---------------------------------------------------------------- counters
    wrap_counter #(
        .MODULUS (imageWidth),
        .WIDTH   (CW)
    ) u_col_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_clear  (w_start_frame),
        .i_enable (w_accept),
        .o_count  (w_col),
        .o_wrap   (w_col_wrap)
    );

    // Row advances on column wrap; its own wrap marks the last pixel of the frame.
    wrap_counter #(
        .MODULUS (imageWidth),
        .WIDTH   (CW)
    ) u_row_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_clear  (w_start_frame),
        .i_enable (w_col_wrap),
        .o_count  (w_row),
        .o_wrap   (w_row_wrap)
    );

    // ------------------------------------------------------------- FSM: state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------- FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_row_wrap) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_out_valid || out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- FSM: outputs
    // A pixel may be taken only if the window slot is free or freed this cycle,
    // so a completing pixel can never overwrite an unconsumed window.
    always_comb begin
        busy     = (r_state != ST_IDLE);
        in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    end

    assign shift_enable = w_accept;

    // ------------------------------------------------------- window register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else if (w_win_complete) begin
            r_out_valid <= 1'b1;
            r_win_row   <= w_row - FW_M1;
            r_win_col   <= w_col - FW_M1;
        end else if (w_win_taken) begin
            r_out_valid <= 1'b0;
        end
    end

    // Pulses in the first IDLE cycle after the last window has been consumed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= (r_state == ST_DRAIN) && (!r_out_valid || out_ready);
        end
    end

    assign out_valid  = r_out_valid;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign frame_done = r_frame_done;

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter bitwidth, default 8, meaning the pixel width used by the controlled line buffers (controller carries no pixel data).
REQ-002 SHALL have parameter imageWidth, default 11, meaning pixels per row and rows per frame (square frame).
REQ-003 SHALL have parameter filterWidth, default 3, meaning the square filter window edge.
REQ-004 SHALL have ports:
  - clock  in  1  single clock; all state updates on posedge.
  - reset_n  in  1  asynchronous, active-low reset.
  - start  in  1  begin a frame; sampled only in IDLE.
  - in_valid  in  1  upstream pixel available.
  - in_ready  out  1  controller accepts a pixel this cycle.
  - shift_enable  out  1  enable to every line-buffer stage.
  - out_valid  out  1  a complete filter window is present in the buffers.
  - out_ready  in  1  downstream MAC consumes the window.
  - win_row  out  CW  top row of the valid window.
  - win_col  out  CW  left column of the valid window.
  - busy  out  1  high whenever state is not IDLE.
  - frame_done  out  1  one-cycle pulse at frame completion.
  - CW = $clog2(imageWidth).

Function
REQ-005 SHALL implement states IDLE, RUN and DRAIN.
REQ-006 SHALL transition IDLE->RUN on start=1 and clear the row and column counters to 0 in that transition.
REQ-007 SHALL ignore start in RUN and DRAIN.
REQ-008 SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready), combinationally.
REQ-009 SHALL treat accept = in_valid && in_ready and drive shift_enable = accept, combinationally; there is no shift without accept.
REQ-010 SHALL on each accept increment col; at col==imageWidth-1 wrap col to 0 and increment row.
REQ-011 SHALL classify an accepted pixel (row,col) as window-completing when row>=filterWidth-1 and col>=filterWidth-1.
REQ-012 SHALL assert out_valid on the cycle after accepting a window-completing pixel, with win_row=row-(filterWidth-1) and win_col=col-(filterWidth-1) registered alongside.
REQ-013 SHALL hold out_valid, win_row and win_col stable until out_valid && out_ready.
REQ-014 SHALL clear out_valid after the handshake unless a new window-completing accept occurs in the same cycle, in which case out_valid stays 1 with the new coordinates.
REQ-015 SHALL enter DRAIN on accepting pixel (imageWidth-1, imageWidth-1); in_ready SHALL be 0 in DRAIN.
REQ-016 SHALL leave DRAIN for IDLE in the cycle after out_valid is 0 (or is handshaked), pulsing frame_done for exactly that cycle.
REQ-017 SHALL produce exactly (imageWidth-filterWidth+1)^2 windows per frame, in raster order.
REQ-018 SHALL ignore in_valid in IDLE and DRAIN; no shift and no counter change.

Reset
REQ-019 SHALL on reset_n=0, asynchronously, force:
  - state=IDLE, row=0, col=0, out_valid=0, win_row=0, win_col=0, frame_done=0;
  - in_ready=0, shift_enable=0, busy=0.
REQ-020 SHALL abandon any frame in progress on reset; the next frame requires a fresh start after reset_n=1.

Structure
REQ-021 SHALL place the state enum typedef and the CW width function in shared package conv_pkg.
REQ-022 SHALL use one sub-module, wrap_counter (parameterised modulus, enable, wrap output), instantiated twice, for col and row.
REQ-023 SHALL keep the line buffers outside this block; the controller connects to them only via shift_enable.

Verification
REQ-024 Defaults; start, then 121 pixels with in_valid=1 and out_ready=1 -> 81 out_valid handshakes; first window (0,0) out_valid in the cycle after pixel index 24; last window (8,8); frame_done one cycle after the last handshake.
REQ-025 out_ready=0 with out_valid=1 -> in_ready=0, shift_enable=0, counters frozen, window held; out_ready=1 -> streaming resumes with no pixel lost or duplicated.
REQ-026 in_valid toggling 1/0 every cycle -> shift_enable mirrors accepts only; 81 windows, correct coordinates.
REQ-027 start pulsed in RUN at pixel 50 -> no effect; the frame completes normally.
REQ-028 reset_n=0 at pixel 60 -> outputs take reset values immediately; a new start restarts at (0,0) with the first window after 25 accepts.
